// File: rtl/pipeline_hazard_scheduler.sv
// Stall/flush scheduler for a 5-stage pipeline without forwarding.
// It tracks in-flight destination registers and can drain the pipeline and freeze it on request.
module pipeline_hazard_scheduler #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_branch_taken,
    input  logic             drain_req,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             id_ex_bubble,
    output logic             if_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [DEPTH-1:0] slot_v_reg;
    logic [4:0]       slot_rd_reg [DEPTH];
    logic [DEPTH-1:0] slot_hit;
    logic [CNT_W-1:0] stall_cycles_reg;
    logic             hazard;
    logic             issue;
    logic             pending_write;

    // A source of x0 never matches because x0 is never marked pending.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign slot_hit[gi] = slot_v_reg[gi] &&
                ((id_uses_rs1 && (id_rs1 != 5'd0) && (slot_rd_reg[gi] == id_rs1)) ||
                 (id_uses_rs2 && (id_rs2 != 5'd0) && (slot_rd_reg[gi] == id_rs2)));
        end
    endgenerate

    assign hazard        = id_valid && (|slot_hit);
    assign issue         = id_valid && !hazard && (state_reg == RUN);
    assign pending_write = issue && id_reg_write && (id_rd != 5'd0);

    // Slot 0 is EX, slot DEPTH-1 is WB; entries advance one stage per clock.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clock) begin
                if (reset) begin
                    slot_v_reg[gi]  <= 1'b0;
                    slot_rd_reg[gi] <= 5'd0;
                end else if (gi == 0) begin
                    slot_v_reg[gi]  <= pending_write;
                    slot_rd_reg[gi] <= issue ? id_rd : 5'd0;
                end else begin
                    slot_v_reg[gi]  <= slot_v_reg[gi-1];
                    slot_rd_reg[gi] <= slot_rd_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= RUN;
            stall_cycles_reg <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == RUN) && hazard && (stall_cycles_reg != {CNT_W{1'b1}})) begin
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (drain_req) state_next = DRAIN;
            DRAIN:   begin
                if (!drain_req) begin
                    state_next = RUN;
                end else if (slot_v_reg == '0) begin
                    state_next = HALTED;
                end
            end
            HALTED:  if (!drain_req) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Everything is frozen unless running hazard-free; the ID instruction is simply held.
    always_comb begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_bubble = 1'b1;
        if_flush     = 1'b0;
        halted       = 1'b0;
        if (!reset) begin
            halted = (state_reg == HALTED);
            if ((state_reg == RUN) && !hazard) begin
                pc_enable    = 1'b1;
                if_id_enable = 1'b1;
                id_ex_bubble = !id_valid;
                if_flush     = id_valid && id_branch_taken;
            end
        end
    end

    assign stall_cycles = stall_cycles_reg;

endmodule
